// File: rtl/output_requant.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : output_requant
// Description : Two-stage requantizer turning signed accumulator lanes into
//               saturated signed activations. Stage 1 rounds and shifts;
//               stage 2 applies optional ReLU, saturates, and emits the word
//               with an auto-incrementing output address.
// Revision    : 1.0 - initial release
// ============================================================================
module output_requant #(
    parameter int N_DIM_ARRAY = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int ACT_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [2:0]                        cfg_mode,
    input  logic [4:0]                        cfg_shift,
    input  logic                              cfg_relu,
    input  logic [31:0]                       cfg_base_addr,
    input  logic [N_DIM_ARRAY*ACC_WIDTH-1:0]  acc_word,
    input  logic                              acc_en,
    output logic [N_DIM_ARRAY*ACT_WIDTH-1:0]  out_word,
    output logic [31:0]                       out_addr,
    output logic                              out_en,
    output logic [2:0]                        out_mode,
    output logic [15:0]                       sat_count,
    output logic                              busy
);

    // One extra bit so the rounding add can never overflow.
    localparam int c_res_width = ACC_WIDTH + 1;
    localparam logic signed [c_res_width-1:0] c_act_max =
        c_res_width'((1 << (ACT_WIDTH - 1)) - 1);
    localparam logic signed [c_res_width-1:0] c_act_min = ~c_act_max;

    logic [2:0]                             r_mode;
    logic [4:0]                             r_shift;
    logic                                   r_relu;
    logic [31:0]                            r_base;
    logic                                   r_s1_valid;
    logic [N_DIM_ARRAY*c_res_width-1:0]     r_s1_data;
    logic [31:0]                            r_k;
    logic                                   r_out_en;
    logic [N_DIM_ARRAY*ACT_WIDTH-1:0]       r_out_word;
    logic [31:0]                            r_out_addr;
    logic [15:0]                            r_sat_count;

    logic [N_DIM_ARRAY*c_res_width-1:0]     w_s1_next;
    logic [N_DIM_ARRAY*ACT_WIDTH-1:0]       w_lane_act;
    logic [N_DIM_ARRAY-1:0]                 w_lane_sat;

    generate
        for (genvar i = 0; i < N_DIM_ARRAY; i++) begin : g_lane
            logic signed [c_res_width-1:0] w_acc_ext;
            logic signed [c_res_width-1:0] w_round;
            logic signed [c_res_width-1:0] w_sum;
            logic signed [c_res_width-1:0] w_res;
            logic [ACT_WIDTH-1:0]          w_act;
            logic                          w_sat;

            assign w_acc_ext = {acc_word[i*ACC_WIDTH + ACC_WIDTH - 1],
                                acc_word[i*ACC_WIDTH +: ACC_WIDTH]};
            assign w_round   = (r_shift == 5'd0) ? '0
                             : (c_res_width'(1) << (r_shift - 5'd1));
            assign w_sum     = w_acc_ext + w_round;
            assign w_s1_next[i*c_res_width +: c_res_width] = w_sum >>> r_shift;

            assign w_res = r_s1_data[i*c_res_width +: c_res_width];

            // ReLU first, then clamp; only the clamp counts as saturation.
            always_comb begin
                w_act = w_res[ACT_WIDTH-1:0];
                w_sat = 1'b0;
                if (r_relu && w_res[c_res_width-1]) begin
                    w_act = '0;
                end else if (w_res > c_act_max) begin
                    w_act = c_act_max[ACT_WIDTH-1:0];
                    w_sat = 1'b1;
                end else if (w_res < c_act_min) begin
                    w_act = c_act_min[ACT_WIDTH-1:0];
                    w_sat = 1'b1;
                end
            end

            assign w_lane_act[i*ACT_WIDTH +: ACT_WIDTH] = w_act;
            assign w_lane_sat[i] = w_sat;
        end
    endgenerate

    // Configuration is captured only on start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode  <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_base  <= '0;
        end else if (start) begin
            r_mode  <= cfg_mode;
            r_shift <= cfg_shift;
            r_relu  <= cfg_relu;
            r_base  <= cfg_base_addr;
        end
    end

    // Stage 1: round and shift; start flushes and drops a coincident word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (start) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= acc_en;
            if (acc_en) begin
                r_s1_data <= w_s1_next;
            end
        end
    end

    // Stage 2: emit saturated word, advance address, count saturated words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_en    <= 1'b0;
            r_out_word  <= '0;
            r_out_addr  <= '0;
            r_k         <= '0;
            r_sat_count <= '0;
        end else if (start) begin
            r_out_en    <= 1'b0;
            r_out_word  <= '0;
            r_k         <= '0;
            r_sat_count <= '0;
        end else if (r_s1_valid) begin
            r_out_en   <= 1'b1;
            r_out_word <= w_lane_act;
            r_out_addr <= r_base + r_k;
            r_k        <= r_k + 32'd1;
            if ((|w_lane_sat) && (r_sat_count != 16'hFFFF)) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
        end else begin
            r_out_en   <= 1'b0;
            r_out_word <= '0;
        end
    end

    assign out_word  = r_out_word;
    assign out_addr  = r_out_addr;
    assign out_en    = r_out_en;
    assign out_mode  = r_mode;
    assign sat_count = r_sat_count;
    assign busy      = r_s1_valid | r_out_en;

endmodule
`default_nettype wire

// File: tb/tb_output_requant.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_output_requant
// Description : Self-checking bench for output_requant: directed scenarios
//               plus randomized streams against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_requant;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int XW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        cfg_mode = '0;
    logic [4:0]        cfg_shift = '0;
    logic              cfg_relu = 1'b0;
    logic [31:0]       cfg_base_addr = '0;
    logic [N*AW-1:0]   acc_word = '0;
    logic              acc_en = 1'b0;
    logic [N*XW-1:0]   out_word;
    logic [31:0]       out_addr;
    logic              out_en;
    logic [2:0]        out_mode;
    logic [15:0]       sat_count;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    output_requant #(.N_DIM_ARRAY(N), .ACC_WIDTH(AW), .ACT_WIDTH(XW)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .cfg_base_addr(cfg_base_addr),
        .acc_word(acc_word), .acc_en(acc_en), .out_word(out_word),
        .out_addr(out_addr), .out_en(out_en), .out_mode(out_mode),
        .sat_count(sat_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: round-half-up shift, optional ReLU, saturation to XW bits.
    function automatic void model_word(input logic [N*AW-1:0] acc, input int sh,
                                       input bit relu, output logic [N*XW-1:0] w,
                                       output bit any_sat);
        longint a, r, hi, lo;
        hi = (longint'(1) << (XW - 1)) - 1;
        lo = -(longint'(1) << (XW - 1));
        any_sat = 1'b0;
        w = '0;
        for (int i = 0; i < N; i++) begin
            a = longint'($signed(acc[i*AW +: AW]));
            r = a + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0));
            r = r >>> sh;
            if (relu && r < 0) r = 0;
            else if (r > hi) begin r = hi; any_sat = 1'b1; end
            else if (r < lo) begin r = lo; any_sat = 1'b1; end
            w[i*XW +: XW] = r[XW-1:0];
        end
    endfunction

    function automatic logic [31:0] rand_lane();
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 600)) - 32'd300;
            default: return 32'($urandom_range(0, 8191)) - 32'd4096;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] sh, input bit relu,
                            input logic [31:0] base, input logic [2:0] mode);
        cfg_shift = sh; cfg_relu = relu; cfg_base_addr = base; cfg_mode = mode;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_checks++;
        if ({out_en, busy, out_mode, sat_count, out_addr, out_word} !== '0)
            $display("FAIL reset_state: en=%b busy=%b mode=%0d sat=%0d addr=%h word=%h, expected all 0",
                     out_en, busy, out_mode, sat_count, out_addr, out_word);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_prestart();
        for (int i = 0; i < N; i++) acc_word[i*AW +: AW] = 32'hFFFF_FFF9;
        acc_en = 1'b1;
        step();
        acc_en = 1'b0;
        n_checks++;
        if (out_en !== 1'b0 || busy !== 1'b1)
            $display("FAIL prestart_latency: en=%b busy=%b, expected en=0 busy=1", out_en, busy);
        else n_pass++;
        step();
        n_checks++;
        if (out_en !== 1'b1 || out_word !== {N{8'hF9}} || out_addr !== 32'h0 || out_mode !== 3'd0)
            $display("FAIL prestart_word: en=%b word=%h addr=%h mode=%0d, expected 1 %h 0 0",
                     out_en, out_word, out_addr, out_mode, {N{8'hF9}});
        else n_pass++;
        step();
    endtask

    task automatic test_basic();
        do_start(5'd4, 1'b0, 32'h100, 3'd1);
        for (int i = 0; i < N; i++) acc_word[i*AW +: AW] = 32'h0000_03F8;
        acc_en = 1'b1;
        step();
        acc_en = 1'b0;
        step();
        n_checks++;
        if (out_en !== 1'b1 || out_word !== {N{8'h40}} || out_addr !== 32'h100 ||
            out_mode !== 3'd1 || sat_count !== 16'd0)
            $display("FAIL basic_word: en=%b word=%h addr=%h mode=%0d sat=%0d, expected 1 %h 100 1 0",
                     out_en, out_word, out_addr, out_mode, sat_count, {N{8'h40}});
        else n_pass++;
        step();
        n_checks++;
        if (out_en !== 1'b0 || out_word !== '0 || out_addr !== 32'h100 || busy !== 1'b0)
            $display("FAIL basic_idle: en=%b word=%h addr=%h busy=%b, expected 0 0 100 0",
                     out_en, out_word, out_addr, busy);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_start(5'd0, 1'b0, 32'h200, 3'd2);
        acc_word = '0;
        acc_word[0*AW +: AW] = 32'd300;
        acc_word[1*AW +: AW] = -32'sd300;
        acc_word[2*AW +: AW] = 32'd127;
        acc_word[3*AW +: AW] = -32'sd128;
        acc_en = 1'b1;
        step();
        acc_word = '0;
        acc_word[0*AW +: AW] = 32'd127;
        acc_word[1*AW +: AW] = -32'sd128;
        step();
        acc_en = 1'b0;
        n_checks++;
        if (out_en !== 1'b1 || out_word !== {32'h0, 32'h807F807F} || out_addr !== 32'h200 ||
            sat_count !== 16'd1)
            $display("FAIL sat_word: en=%b word=%h addr=%h sat=%0d, expected 1 %h 200 1",
                     out_en, out_word, out_addr, sat_count, {32'h0, 32'h807F807F});
        else n_pass++;
        step();
        n_checks++;
        if (out_en !== 1'b1 || out_word !== {48'h0, 16'h807F} || out_addr !== 32'h201 ||
            sat_count !== 16'd1)
            $display("FAIL sat_boundary: en=%b word=%h addr=%h sat=%0d, expected 1 %h 201 1",
                     out_en, out_word, out_addr, sat_count, {48'h0, 16'h807F});
        else n_pass++;
        step();
    endtask

    task automatic test_relu();
        do_start(5'd2, 1'b1, 32'h300, 3'd0);
        acc_word = '0;
        acc_word[0*AW +: AW] = -32'sd50;
        acc_word[1*AW +: AW] = 32'd6;
        acc_word[2*AW +: AW] = -32'sd100000;
        acc_en = 1'b1;
        step();
        acc_en = 1'b0;
        step();
        n_checks++;
        if (out_en !== 1'b1 || out_word !== {40'h0, 24'h000200} || sat_count !== 16'd0)
            $display("FAIL relu_word: en=%b word=%h sat=%0d, expected 1 %h 0",
                     out_en, out_word, sat_count, {40'h0, 24'h000200});
        else n_pass++;
        step();
    endtask

    task automatic test_addr_wrap();
        logic [31:0] exp_addr;
        logic [7:0]  lane_val;
        do_start(5'd0, 1'b0, 32'hFFFF_FFFE, 3'd0);
        for (int c = 0; c < 10; c++) begin
            acc_en = (c < 8);
            for (int i = 0; i < N; i++) acc_word[i*AW +: AW] = 32'(c);
            step();
            n_checks++;
            if (out_en !== (c >= 1 && c <= 8))
                $display("FAIL wrap_en[%0d]: got %b expected %b", c, out_en, (c >= 1 && c <= 8));
            else n_pass++;
            if (c >= 1 && c <= 8) begin
                exp_addr = 32'hFFFF_FFFE + 32'(c - 1);
                lane_val = 8'(c - 1);
                n_checks++;
                if (out_addr !== exp_addr || out_word !== {N{lane_val}})
                    $display("FAIL wrap_data[%0d]: addr=%h word=%h, expected %h %h",
                             c, out_addr, out_word, exp_addr, {N{lane_val}});
                else n_pass++;
            end
        end
        acc_en = 1'b0;
        n_checks++;
        if (out_addr !== 32'h5)
            $display("FAIL wrap_hold: addr=%h expected 00000005", out_addr);
        else n_pass++;
    endtask

    task automatic test_start_flush();
        do_start(5'd0, 1'b0, 32'h400, 3'd0);
        for (int i = 0; i < N; i++) acc_word[i*AW +: AW] = 32'd1;
        acc_en = 1'b1;
        step();
        for (int i = 0; i < N; i++) acc_word[i*AW +: AW] = 32'd2;
        cfg_base_addr = 32'h500;
        start = 1'b1;
        step();
        start = 1'b0;
        acc_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (out_en !== 1'b0 || busy !== 1'b0)
                $display("FAIL flush[%0d]: en=%b busy=%b, expected 0 0", c, out_en, busy);
            else n_pass++;
            step();
        end
        for (int i = 0; i < N; i++) acc_word[i*AW +: AW] = 32'd3;
        acc_en = 1'b1;
        step();
        acc_en = 1'b0;
        step();
        n_checks++;
        if (out_en !== 1'b1 || out_addr !== 32'h500 || out_word !== {N{8'h03}})
            $display("FAIL flush_newbase: en=%b addr=%h word=%h, expected 1 500 %h",
                     out_en, out_addr, out_word, {N{8'h03}});
        else n_pass++;
        step();
    endtask

    task automatic test_reset_midstream();
        do_start(5'd0, 1'b0, 32'h600, 3'd5);
        for (int i = 0; i < N; i++) acc_word[i*AW +: AW] = 32'd9;
        acc_en = 1'b1;
        step();
        acc_en = 1'b0;
        step();
        acc_en = 1'b1;
        step();
        acc_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out_en, busy, out_mode, sat_count, out_addr, out_word} !== '0)
            $display("FAIL midreset_state: en=%b busy=%b mode=%0d sat=%0d addr=%h word=%h, expected all 0",
                     out_en, busy, out_mode, sat_count, out_addr, out_word);
        else n_pass++;
        step();
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (out_en !== 1'b0 || busy !== 1'b0)
                $display("FAIL midreset_quiet[%0d]: en=%b busy=%b, expected 0 0", c, out_en, busy);
            else n_pass++;
        end
    endtask

    task automatic test_random(input int iter);
        bit              exp_v [0:63];
        bit              exp_s [0:63];
        logic [N*XW-1:0] exp_w [0:63];
        logic [31:0]     exp_addr;
        logic [31:0]     base;
        logic [2:0]      mode;
        logic [N*AW-1:0] word;
        int              sh;
        bit              relu;
        int              exp_sat;
        for (int c = 0; c < 64; c++) begin exp_v[c] = 0; exp_s[c] = 0; exp_w[c] = '0; end
        sh   = $urandom_range(0, 14);
        relu = 1'($urandom_range(0, 1));
        base = $urandom;
        mode = 3'($urandom_range(0, 7));
        do_start(5'(sh), relu, base, mode);
        exp_addr = base;
        exp_sat  = 0;
        for (int c = 0; c < 52; c++) begin
            n_checks++;
            if (out_en !== exp_v[c] || out_mode !== mode)
                $display("FAIL rand%0d_en[%0d]: en=%b mode=%0d, expected %b %0d",
                         iter, c, out_en, out_mode, exp_v[c], mode);
            else n_pass++;
            if (exp_v[c]) begin
                if (exp_s[c] && exp_sat < 16'hFFFF) exp_sat++;
                n_checks++;
                if (out_word !== exp_w[c] || out_addr !== exp_addr || sat_count !== 16'(exp_sat))
                    $display("FAIL rand%0d_data[%0d]: word=%h addr=%h sat=%0d, expected %h %h %0d",
                             iter, c, out_word, out_addr, sat_count, exp_w[c], exp_addr, exp_sat);
                else n_pass++;
                exp_addr = exp_addr + 32'd1;
            end
            acc_en = (c < 46) && ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) word[i*AW +: AW] = rand_lane();
            acc_word = word;
            if (acc_en) begin
                exp_v[c+2] = 1'b1;
                model_word(word, sh, relu, exp_w[c+2], exp_s[c+2]);
            end
            cfg_shift = 5'($urandom); cfg_relu = 1'($urandom);
            cfg_base_addr = $urandom; cfg_mode = 3'($urandom);
            step();
        end
        acc_en = 1'b0;
        n_checks++;
        if (sat_count !== 16'(exp_sat) || busy !== 1'b0)
            $display("FAIL rand%0d_final: sat=%0d busy=%b, expected %0d 0", iter, sat_count, busy, exp_sat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_prestart();
        test_basic();
        test_saturation();
        test_relu();
        test_addr_wrap();
        test_start_flush();
        test_reset_midstream();
        for (int k = 0; k < 4; k++) test_random(k);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
